// File: rtl/regfile_ctrl_pkg.sv
// Shared opcodes, FSM state encoding and default widths for the register-file op sequencer.
package regfile_ctrl_pkg;

  localparam int DEF_DW = 8;
  localparam int DEF_AW = 3;

  localparam logic [2:0] OP_NOP   = 3'd0;
  localparam logic [2:0] OP_LOADI = 3'd1;
  localparam logic [2:0] OP_ADD   = 3'd2;
  localparam logic [2:0] OP_SUB   = 3'd3;
  localparam logic [2:0] OP_AND   = 3'd4;
  localparam logic [2:0] OP_OR    = 3'd5;
  localparam logic [2:0] OP_XOR   = 3'd6;
  localparam logic [2:0] OP_CLEAR = 3'd7;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_READ  = 3'd1,
    ST_EXEC  = 3'd2,
    ST_WRITE = 3'd3,
    ST_CLEAR = 3'd4
  } state_t;

endpackage

// File: rtl/alu8.sv
// Combinational ALU: LOADI passes the immediate, ADD/SUB report carry/borrow, logic ops clear carry.
module alu8
  import regfile_ctrl_pkg::*;
#(
  parameter int W = DEF_DW
) (
  input  logic [2:0]   op,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic [W-1:0] imm,
  output logic [W-1:0] y,
  output logic         c
);

  logic [W:0] sum;
  logic [W:0] diff;

  // The extra top bit of diff is the borrow, set exactly when a < b.
  assign sum  = {1'b0, a} + {1'b0, b};
  assign diff = {1'b0, a} - {1'b0, b};

  always_comb begin
    y = '0;
    c = 1'b0;
    case (op)
      OP_LOADI: y = imm;
      OP_ADD:   begin y = sum[W-1:0];  c = sum[W];  end
      OP_SUB:   begin y = diff[W-1:0]; c = diff[W]; end
      OP_AND:   y = a & b;
      OP_OR:    y = a | b;
      OP_XOR:   y = a ^ b;
      default:  y = '0;
    endcase
  end

endmodule

// File: rtl/regfile_op_sequencer.sv
// Command sequencer for an external register file: read operands, run the ALU, write back, or bulk-clear.
// Handshake: a command transfers on a rising edge where cmd_valid && cmd_ready; cmd_ready is high only in IDLE.
module regfile_op_sequencer
  import regfile_ctrl_pkg::*;
#(
  parameter int DW = DEF_DW,
  parameter int AW = DEF_AW
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cmd_valid,
  output logic          cmd_ready,
  input  logic [2:0]    cmd_op,
  input  logic [AW-1:0] cmd_rd,
  input  logic [AW-1:0] cmd_rs0,
  input  logic [AW-1:0] cmd_rs1,
  input  logic [DW-1:0] cmd_imm,
  output logic [AW-1:0] rf_read_addr0,
  output logic [AW-1:0] rf_read_addr1,
  input  logic [DW-1:0] rf_read_data0,
  input  logic [DW-1:0] rf_read_data1,
  output logic [AW-1:0] rf_write_addr,
  output logic [DW-1:0] rf_write_data,
  output logic          rf_write_enable,
  output logic          done,
  output logic [DW-1:0] result,
  output logic          flag_z,
  output logic          flag_c,
  output logic          busy,
  output state_t        state_dbg
);

  localparam logic [AW-1:0] CNT_LAST = {AW{1'b1}};

  state_t        state;
  logic [2:0]    op_q;
  logic [AW-1:0] rd_q, rs0_q, rs1_q, cnt;
  logic [AW-1:0] cnt_next;
  logic [DW-1:0] imm_q, a_q, b_q;
  logic [DW-1:0] alu_y;
  logic          alu_c;

  assign cnt_next      = cnt + 1'b1;
  assign rf_read_addr0 = rs0_q;
  assign rf_read_addr1 = rs1_q;
  assign busy          = ~cmd_ready;
  assign state_dbg     = state;

  alu8 #(.W(DW)) u_alu (
    .op  (op_q),
    .a   (a_q),
    .b   (b_q),
    .imm (imm_q),
    .y   (alu_y),
    .c   (alu_c)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state           <= ST_IDLE;
      cmd_ready       <= 1'b1;
      done            <= 1'b0;
      rf_write_enable <= 1'b0;
      rf_write_addr   <= '0;
      rf_write_data   <= '0;
      result          <= '0;
      flag_z          <= 1'b0;
      flag_c          <= 1'b0;
      cnt             <= '0;
      op_q            <= OP_NOP;
      rd_q            <= '0;
      rs0_q           <= '0;
      rs1_q           <= '0;
      imm_q           <= '0;
      a_q             <= '0;
      b_q             <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (cmd_valid && cmd_ready) begin
            op_q      <= cmd_op;
            rd_q      <= cmd_rd;
            rs0_q     <= cmd_rs0;
            rs1_q     <= cmd_rs1;
            imm_q     <= cmd_imm;
            cmd_ready <= 1'b0;
            if (cmd_op == OP_CLEAR) begin
              state           <= ST_CLEAR;
              cnt             <= '0;
              rf_write_enable <= 1'b1;
              rf_write_addr   <= '0;
              rf_write_data   <= '0;
              result          <= '0;
              flag_z          <= 1'b1;
              flag_c          <= 1'b0;
            end else if (cmd_op == OP_NOP) begin
              state <= ST_WRITE;
              done  <= 1'b1;
            end else begin
              state <= ST_READ;
            end
          end
        end
        ST_READ: begin
          a_q   <= rf_read_data0;
          b_q   <= rf_read_data1;
          state <= ST_EXEC;
        end
        ST_EXEC: begin
          result          <= alu_y;
          flag_z          <= (alu_y == '0);
          flag_c          <= alu_c;
          done            <= 1'b1;
          rf_write_enable <= (op_q != OP_NOP);
          rf_write_addr   <= rd_q;
          rf_write_data   <= alu_y;
          state           <= ST_WRITE;
        end
        ST_WRITE: begin
          done            <= 1'b0;
          rf_write_enable <= 1'b0;
          cmd_ready       <= 1'b1;
          state           <= ST_IDLE;
        end
        ST_CLEAR: begin
          // done is raised together with the write of the last register.
          if (cnt == CNT_LAST) begin
            done            <= 1'b0;
            rf_write_enable <= 1'b0;
            cmd_ready       <= 1'b1;
            state           <= ST_IDLE;
          end else begin
            cnt           <= cnt_next;
            rf_write_addr <= cnt_next;
            done          <= (cnt_next == CNT_LAST);
          end
        end
        default: begin
          done            <= 1'b0;
          rf_write_enable <= 1'b0;
          cmd_ready       <= 1'b1;
          state           <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_regfile_op_sequencer.sv
// Bench: sequencer plus a behavioural 8x8 register file, checked against an array-based reference model.
module tb_regfile_op_sequencer;
  import regfile_ctrl_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [2:0] cmd_op, cmd_rd, cmd_rs0, cmd_rs1;
  logic [7:0] cmd_imm;
  logic [2:0] rf_read_addr0, rf_read_addr1, rf_write_addr;
  logic [7:0] rf_read_data0, rf_read_data1, rf_write_data;
  logic       rf_write_enable, done, flag_z, flag_c, busy;
  logic [7:0] result;
  state_t     state_dbg;

  int n_cmp  = 0;
  int n_fail = 0;

  // Register file next to the sequencer: combinational reads, clocked write.
  logic [7:0] rf [8];
  always @(posedge clk) if (rf_write_enable) rf[rf_write_addr] <= rf_write_data;
  assign rf_read_data0 = rf[rf_read_addr0];
  assign rf_read_data1 = rf[rf_read_addr1];

  // Reference model state.
  logic [7:0]  exp_rf [8];
  logic [7:0]  exp_result;
  logic        exp_z, exp_c;
  logic [10:0] exp_q [$];

  regfile_op_sequencer dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_rd(cmd_rd), .cmd_rs0(cmd_rs0), .cmd_rs1(cmd_rs1), .cmd_imm(cmd_imm),
    .rf_read_addr0(rf_read_addr0), .rf_read_addr1(rf_read_addr1),
    .rf_read_data0(rf_read_data0), .rf_read_data1(rf_read_data1),
    .rf_write_addr(rf_write_addr), .rf_write_data(rf_write_data), .rf_write_enable(rf_write_enable),
    .done(done), .result(result), .flag_z(flag_z), .flag_c(flag_c), .busy(busy), .state_dbg(state_dbg)
  );

  always #5 clk = ~clk;

  // Apply one command to the model with plain integer arithmetic; wr tells whether a register is written.
  function automatic void ref_apply(input logic [2:0] op, input logic [2:0] rd, rs0, rs1,
                                    input logic [7:0] imm, output logic [7:0] y, output logic wr);
    int a, b, s;
    a  = int'(exp_rf[rs0]);
    b  = int'(exp_rf[rs1]);
    s  = 0;
    wr = 1'b0;
    y  = exp_result;
    if (op == OP_CLEAR) begin
      for (int i = 0; i < 8; i++) exp_rf[i] = 8'h00;
      exp_result = 8'h00; exp_z = 1'b1; exp_c = 1'b0; y = 8'h00;
    end else if (op != OP_NOP) begin
      case (op)
        OP_LOADI: s = int'(imm);
        OP_ADD:   s = a + b;
        OP_SUB:   s = a - b;
        OP_AND:   s = a & b;
        OP_OR:    s = a | b;
        OP_XOR:   s = a ^ b;
        default:  s = 0;
      endcase
      exp_c      = (op == OP_ADD) ? (s > 255) : (op == OP_SUB) ? (s < 0) : 1'b0;
      y          = 8'((s + 256) % 256);
      exp_result = y;
      exp_z      = (y == 8'h00);
      exp_rf[rd] = y;
      wr         = 1'b1;
    end
  endfunction

  task automatic run_cmd(input logic [2:0] op, input logic [2:0] rd, rs0, rs1, input logic [7:0] imm,
                         input string name);
    int k, lat;
    logic [7:0] y;
    logic wr;
    ref_apply(op, rd, rs0, rs1, imm, y, wr);
    lat = (op == OP_NOP) ? 1 : (op == OP_CLEAR) ? 8 : 3;
    cmd_op = op; cmd_rd = rd; cmd_rs0 = rs0; cmd_rs1 = rs1; cmd_imm = imm; cmd_valid = 1'b1;
    k = 0;
    while (!cmd_ready && k < 20) begin @(negedge clk); k++; end
    n_cmp++;
    if (cmd_ready !== 1'b1) begin n_fail++; $display("FAIL %s accept: cmd_ready %b required 1", name, cmd_ready); end
    @(negedge clk);
    cmd_valid = 1'b0;
    cmd_op = 3'($urandom_range(0, 7)); cmd_rd = 3'($urandom); cmd_imm = 8'($urandom);
    k = 1;
    while (done !== 1'b1 && k < 20) begin
      n_cmp++;
      if (op == OP_CLEAR) begin
        if ({rf_write_enable, rf_write_addr, rf_write_data} !== {1'b1, 3'(k - 1), 8'h00}) begin
          n_fail++;
          $display("FAIL %s clear_write: got we=%b addr=%0d data=%h required we=1 addr=%0d data=00",
                   name, rf_write_enable, rf_write_addr, rf_write_data, k - 1);
        end
      end else if (rf_write_enable !== 1'b0) begin
        n_fail++; $display("FAIL %s early_write: we=%b required 0", name, rf_write_enable);
      end
      @(negedge clk); k++;
    end
    n_cmp++;
    if (k != lat) begin n_fail++; $display("FAIL %s latency: got %0d required %0d", name, k, lat); end
    n_cmp++;
    if (op == OP_CLEAR) begin
      if ({rf_write_enable, rf_write_addr, rf_write_data} !== {1'b1, 3'd7, 8'h00}) begin
        n_fail++; $display("FAIL %s clear_last: we=%b addr=%0d data=%h required 1/7/00",
                           name, rf_write_enable, rf_write_addr, rf_write_data);
      end
    end else if (wr) begin
      if ({rf_write_enable, rf_write_addr, rf_write_data} !== {1'b1, rd, y}) begin
        n_fail++; $display("FAIL %s write: we=%b addr=%0d data=%h required 1/%0d/%h",
                           name, rf_write_enable, rf_write_addr, rf_write_data, rd, y);
      end
    end else if (rf_write_enable !== 1'b0) begin
      n_fail++; $display("FAIL %s nop_write: we=%b required 0", name, rf_write_enable);
    end
    @(negedge clk);
    n_cmp++;
    if ({cmd_ready, done, result, flag_z, flag_c} !== {1'b1, 1'b0, exp_result, exp_z, exp_c}) begin
      n_fail++; $display("FAIL %s status: ready=%b done=%b result=%h z=%b c=%b required 1/0/%h/%b/%b",
                         name, cmd_ready, done, result, flag_z, flag_c, exp_result, exp_z, exp_c);
    end
    for (int i = 0; i < 8; i++) begin
      n_cmp++;
      if (rf[i] !== exp_rf[i]) begin
        n_fail++; $display("FAIL %s reg%0d: got %h required %h", name, i, rf[i], exp_rf[i]);
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; cmd_valid = 1'b0;
    cmd_op = OP_NOP; cmd_rd = '0; cmd_rs0 = '0; cmd_rs1 = '0; cmd_imm = '0;
    exp_result = 8'h00; exp_z = 1'b0; exp_c = 1'b0;
    for (int i = 0; i < 8; i++) exp_rf[i] = 8'h00;
    repeat (3) @(negedge clk);
    n_cmp++;
    if ({cmd_ready, busy, done, rf_write_enable} !== 4'b1000) begin
      n_fail++; $display("FAIL reset_ctrl: ready/busy/done/we=%b required 1000",
                         {cmd_ready, busy, done, rf_write_enable});
    end
    n_cmp++;
    if ({result, flag_z, flag_c} !== 10'h000 || state_dbg !== ST_IDLE) begin
      n_fail++; $display("FAIL reset_data: result=%h z=%b c=%b state=%0d required 00/0/0/IDLE",
                         result, flag_z, flag_c, state_dbg);
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_clear();
    run_cmd(OP_CLEAR, 3'd0, 3'd0, 3'd0, 8'h00, "clear");
  endtask

  task automatic test_directed();
    run_cmd(OP_LOADI, 3'd1, 3'd0, 3'd0, 8'h2A, "loadi_r1");
    run_cmd(OP_LOADI, 3'd2, 3'd0, 3'd0, 8'h10, "loadi_r2");
    run_cmd(OP_ADD,   3'd3, 3'd1, 3'd2, 8'h00, "add_r3");
    n_cmp++;
    if ({rf[3], flag_z, flag_c} !== {8'h3A, 1'b0, 1'b0}) begin
      n_fail++; $display("FAIL add_const: r3=%h z=%b c=%b required 3A/0/0", rf[3], flag_z, flag_c);
    end
    run_cmd(OP_LOADI, 3'd4, 3'd0, 3'd0, 8'hF0, "loadi_r4");
    run_cmd(OP_ADD,   3'd5, 3'd4, 3'd2, 8'h00, "add_r5");
    n_cmp++;
    if ({rf[5], flag_z, flag_c} !== {8'h00, 1'b1, 1'b1}) begin
      n_fail++; $display("FAIL add_wrap_const: r5=%h z=%b c=%b required 00/1/1", rf[5], flag_z, flag_c);
    end
    run_cmd(OP_SUB,   3'd6, 3'd2, 3'd1, 8'h00, "sub_r6");
    n_cmp++;
    if ({rf[6], flag_c} !== {8'hE6, 1'b1}) begin
      n_fail++; $display("FAIL sub_const: r6=%h c=%b required E6/1", rf[6], flag_c);
    end
    run_cmd(OP_XOR,   3'd1, 3'd1, 3'd1, 8'h00, "xor_self");
    n_cmp++;
    if ({rf[1], flag_z} !== {8'h00, 1'b1}) begin
      n_fail++; $display("FAIL xor_self_const: r1=%h z=%b required 00/1", rf[1], flag_z);
    end
    run_cmd(OP_NOP,   3'd7, 3'd0, 3'd0, 8'h55, "nop");
  endtask

  task automatic test_random();
    logic [2:0] op;
    for (int n = 0; n < 40; n++) begin
      op = ($urandom_range(0, 9) == 0) ? OP_CLEAR : 3'($urandom_range(0, 6));
      run_cmd(op, 3'($urandom), 3'($urandom), 3'($urandom), 8'($urandom), "random");
    end
  endtask

  task automatic test_back_to_back();
    logic [2:0] ops [12], rds [12], r0s [12], r1s [12];
    logic [7:0] imms [12];
    logic [7:0] y;
    logic       wr, acc;
    logic [10:0] got;
    int idx, gap, exp_gap;
    for (int i = 0; i < 12; i++) begin
      ops[i] = 3'($urandom_range(0, 6)); rds[i] = 3'($urandom);
      r0s[i] = 3'($urandom); r1s[i] = 3'($urandom); imms[i] = 8'($urandom);
    end
    idx = 0; gap = 0; exp_gap = 0;
    cmd_op = ops[0]; cmd_rd = rds[0]; cmd_rs0 = r0s[0]; cmd_rs1 = r1s[0]; cmd_imm = imms[0];
    cmd_valid = 1'b1;
    for (int cyc = 0; cyc < 200 && (idx < 12 || exp_q.size() > 0); cyc++) begin
      if (rf_write_enable === 1'b1) begin
        n_cmp++;
        got = {rf_write_addr, rf_write_data};
        if (exp_q.size() == 0) begin
          n_fail++; $display("FAIL b2b_extra_write: got %h with nothing expected", got);
        end else if (got !== exp_q[0]) begin
          n_fail++; $display("FAIL b2b_write: got %h required %h", got, exp_q[0]);
          void'(exp_q.pop_front());
        end else begin
          void'(exp_q.pop_front());
        end
      end
      acc = cmd_valid && cmd_ready;
      if (acc) begin
        if (idx > 0) begin
          n_cmp++;
          if (gap != exp_gap) begin n_fail++; $display("FAIL b2b_gap: got %0d required %0d", gap, exp_gap); end
        end
        ref_apply(ops[idx], rds[idx], r0s[idx], r1s[idx], imms[idx], y, wr);
        if (wr) exp_q.push_back({rds[idx], y});
        exp_gap = (ops[idx] == OP_NOP) ? 1 : 3;
        idx++; gap = 0;
      end else if (!cmd_ready) begin
        gap++;
      end
      @(negedge clk);
      if (acc) begin
        if (idx < 12) begin
          cmd_op = ops[idx]; cmd_rd = rds[idx]; cmd_rs0 = r0s[idx]; cmd_rs1 = r1s[idx]; cmd_imm = imms[idx];
        end else begin
          cmd_valid = 1'b0;
        end
      end
    end
    cmd_valid = 1'b0;
    n_cmp++;
    if (idx != 12 || exp_q.size() != 0) begin
      n_fail++; $display("FAIL b2b_count: accepted %0d pending %0d required 12/0", idx, exp_q.size());
    end
    repeat (2) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      n_cmp++;
      if (rf[i] !== exp_rf[i]) begin
        n_fail++; $display("FAIL b2b_reg%0d: got %h required %h", i, rf[i], exp_rf[i]);
      end
    end
  endtask

  task automatic test_reset_mid_clear();
    for (int i = 0; i < 8; i++)
      run_cmd(OP_LOADI, 3'(i), 3'd0, 3'd0, 8'($urandom_range(1, 255)), "preload");
    cmd_op = OP_CLEAR; cmd_valid = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b0;
    repeat (3) @(negedge clk);
    n_cmp++;
    if ({rf_write_enable, rf_write_addr} !== {1'b1, 3'd3}) begin
      n_fail++; $display("FAIL midclr_4th: we=%b addr=%0d required 1/3", rf_write_enable, rf_write_addr);
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    n_cmp++;
    if ({rf_write_enable, cmd_ready, done} !== 3'b010) begin
      n_fail++; $display("FAIL midclr_abort: we/ready/done=%b required 010",
                         {rf_write_enable, cmd_ready, done});
    end
    for (int i = 0; i < 4; i++) exp_rf[i] = 8'h00;
    exp_result = 8'h00; exp_z = 1'b0; exp_c = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (rf_write_enable !== 1'b0) begin
      n_fail++; $display("FAIL midclr_quiet: we=%b required 0", rf_write_enable);
    end
    for (int i = 0; i < 8; i++) begin
      n_cmp++;
      if (rf[i] !== exp_rf[i]) begin
        n_fail++; $display("FAIL midclr_reg%0d: got %h required %h", i, rf[i], exp_rf[i]);
      end
    end
    run_cmd(OP_ADD, 3'd0, 3'd5, 3'd6, 8'h00, "after_reset_add");
  endtask

  initial begin
    test_reset();
    test_clear();
    test_directed();
    test_random();
    test_back_to_back();
    test_reset_mid_clear();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
